regfile_wb_arbiter: RTL

Write-port arbiter and sequencer for the general-purpose register file. Two writeback requesters (ALU and LSU) share the register file's single write port through valid/ready handshakes. The block picks one winner per cycle with round-robin fairness, registers the winning write for one cycle, and drives the register file's write-enable, address and data. An optional forwarding path lets register-file reads see the write that is in flight.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request bundle.
package regfile_pkg;

    localparam int GEN_REG_COUNT  = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 64;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; prio 0 favours req[0], 1 favours req[1].
module rr_arbiter2 (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       stall_in,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;
    logic prio_nxt;

    always_comb begin
        gnt      = 2'b00;
        prio_nxt = prio;
        if (!(reset || stall_in)) begin
            unique case (1'b1)
                (req == 2'b11): begin
                    gnt      = prio ? 2'b10 : 2'b01;
                    // loser gets priority next time
                    prio_nxt = ~prio;
                end
                (req == 2'b01): gnt = 2'b01;
                (req == 2'b10): gnt = 2'b10;
                default:        gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) prio <= 1'b0;
        else       prio <= prio_nxt;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter for the register file (ALU vs LSU).
// Optional read forwarding of the in-flight write: define WB_FWD_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = 6,
    localparam int W = 1 << REG_DATA_WIDTH_POW
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      stall_in,
    input  logic                      aluWbValid_in,
    input  logic [REG_ADDR_WIDTH-1:0] aluWbRd_in,
    input  logic [W-1:0]              aluWbData_in,
    output logic                      aluWbReady_out,
    input  logic                      lsuWbValid_in,
    input  logic [REG_ADDR_WIDTH-1:0] lsuWbRd_in,
    input  logic [W-1:0]              lsuWbData_in,
    output logic                      lsuWbReady_out,
`ifdef WB_FWD_EN
    input  logic [REG_ADDR_WIDTH-1:0] rs1_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_in,
    input  logic [W-1:0]              rfData1_in,
    input  logic [W-1:0]              rfData2_in,
    output logic [W-1:0]              regData1_out,
    output logic [W-1:0]              regData2_out,
`endif
    output logic                      regWrite_ctrl_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic [W-1:0]              writeData_out
);

    logic [1:0]                req;
    logic [1:0]                gnt;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [W-1:0]              sel_data;
    logic                      we_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [W-1:0]              data_q;

    assign req = {lsuWbValid_in, aluWbValid_in};

    rr_arbiter2 u_arb (
        .clk_in   (clk_in),
        .reset    (reset),
        .stall_in (stall_in),
        .req      (req),
        .gnt      (gnt)
    );

    assign aluWbReady_out = gnt[0];
    assign lsuWbReady_out = gnt[1];

    always_comb begin
        sel_rd   = aluWbRd_in;
        sel_data = aluWbData_in;
        if (gnt[1]) begin
            sel_rd   = lsuWbRd_in;
            sel_data = lsuWbData_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (gnt != 2'b00) begin
            // x0 writes are accepted but never enabled
            we_q   <= (sel_rd != '0);
            rd_q   <= sel_rd;
            data_q <= sel_data;
        end else begin
            we_q   <= 1'b0;
        end
    end

    // reset kills a held write before the register file can commit it
    assign regWrite_ctrl_out = we_q & ~reset;
    assign rd_out            = rd_q;
    assign writeData_out     = data_q;

`ifdef WB_FWD_EN
    assign regData1_out = (regWrite_ctrl_out && rs1_in == rd_q)
                        ? data_q : rfData1_in;
    assign regData2_out = (regWrite_ctrl_out && rs2_in == rd_q)
                        ? data_q : rfData2_in;
`endif

endmodule
